// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and encodings for the pipeline hazard controller.
//               Forwarding-select codes are shared by the EX and ID muxes.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Default register-address width (32 architectural registers)
  localparam int DEF_REG_AW = 5;

  // Operand source select for the EX and ID forwarding muxes
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Iterative mul/div unit tracking state
  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Single-operand forwarding select. The younger producer (MEM)
//               wins over the older one (WB) when both target the same reg.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  logic              i_mem_wr,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_wb_wr,
  input  logic [REG_AW-1:0] i_wb_dst,
  output logic [1:0]        o_sel
);

  // $0 is hardwired, so it never takes a forwarded value
  always_comb begin
    o_sel = FWD_REG;
    if (i_use && (i_src != '0)) begin
      if (i_mem_wr && (i_mem_dst == i_src)) begin
        o_sel = FWD_MEM;
      end else if (i_wb_wr && (i_wb_dst == i_src)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit
// Description : Hazard controller for a 5-stage MIPS pipeline with branches
//               and jumps resolved in ID. Produces PC / IF-ID hold, flushes,
//               EX and ID forwarding selects, tracks the iterative mul/div
//               unit and keeps saturating stall / flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW        = DEF_REG_AW,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_br_taken,
  input  logic              id_jump,
  input  logic              id_muldiv,
  input  logic              id_hilo_rd,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_regwr,
  input  logic              ex_memrd,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_regwr,
  input  logic              mem_memrd,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              wb_regwr,
  input  logic [REG_AW-1:0] wb_dst,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_ex_a,
  output logic [1:0]        fwd_ex_b,
  output logic [1:0]        fwd_id_a,
  output logic [1:0]        fwd_id_b,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int                   MD_CNT_W = $clog2(MULDIV_CYCLES);
  localparam logic [MD_CNT_W-1:0]  C_MD_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

  md_state_t             md_state_q, md_state_d;
  logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic                  md_busy_q, md_busy_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic w_ex_rs, w_ex_rt;     // any EX producer feeds an ID source
  logic w_ld_rs, w_ld_rt;     // EX load feeds an ID source
  logic w_mld_rs, w_mld_rt;   // MEM load feeds an ID source
  logic w_md_stall, w_load_use, w_br_stall, w_jr_stall, w_any_stall;
  logic w_mem_id_wr;

  // A producer hazards a source only if the source is real, used and written
  function automatic logic hz_match(input logic [REG_AW-1:0] src,
                                    input logic              use_src,
                                    input logic              wr,
                                    input logic [REG_AW-1:0] dst);
    return (src != '0) && use_src && wr && (dst == src);
  endfunction

  // Producer/consumer matches and the stall causes derived from them
  always_comb begin
    w_ex_rs  = hz_match(id_rs, id_use_rs, ex_regwr,  ex_dst);
    w_ex_rt  = hz_match(id_rt, id_use_rt, ex_regwr,  ex_dst);
    w_ld_rs  = hz_match(id_rs, id_use_rs, ex_memrd,  ex_dst);
    w_ld_rt  = hz_match(id_rt, id_use_rt, ex_memrd,  ex_dst);
    w_mld_rs = hz_match(id_rs, id_use_rs, mem_memrd, mem_dst);
    w_mld_rt = hz_match(id_rt, id_use_rt, mem_memrd, mem_dst);

    w_md_stall  = md_busy_q && (id_muldiv || id_hilo_rd);
    w_load_use  = w_ld_rs || w_ld_rt;
    // ID compare needs operands now: an EX result is too late, and a load in
    // MEM has no data until WB
    w_br_stall  = id_branch && (w_ex_rs || w_ex_rt || w_mld_rs || w_mld_rt);
    // jr reads only rs
    w_jr_stall  = id_jump && (w_ex_rs || w_mld_rs);
    w_any_stall = w_md_stall || w_load_use || w_br_stall || w_jr_stall;
  end

  // Pipeline enables and flushes; a stall overrides any redirect
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (w_any_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_jump || (id_branch && id_br_taken)) begin
      if_id_flush = 1'b1;
    end
  end

  // A load in MEM has no data yet, so it is hidden from the ID muxes
  assign w_mem_id_wr = mem_regwr && !mem_memrd;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_ex_a (
    .i_src(ex_rs), .i_use(1'b1), .i_mem_wr(mem_regwr), .i_mem_dst(mem_dst),
    .i_wb_wr(wb_regwr), .i_wb_dst(wb_dst), .o_sel(fwd_ex_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_ex_b (
    .i_src(ex_rt), .i_use(1'b1), .i_mem_wr(mem_regwr), .i_mem_dst(mem_dst),
    .i_wb_wr(wb_regwr), .i_wb_dst(wb_dst), .o_sel(fwd_ex_b)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_id_a (
    .i_src(id_rs), .i_use(id_use_rs), .i_mem_wr(w_mem_id_wr), .i_mem_dst(mem_dst),
    .i_wb_wr(wb_regwr), .i_wb_dst(wb_dst), .o_sel(fwd_id_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_id_b (
    .i_src(id_rt), .i_use(id_use_rt), .i_mem_wr(w_mem_id_wr), .i_mem_dst(mem_dst),
    .i_wb_wr(wb_regwr), .i_wb_dst(wb_dst), .o_sel(fwd_id_b)
  );

  // Mul/div tracker next state: counts down the latency once issued
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (id_muldiv && !w_any_stall) begin
          md_state_d = MD_BUSY;
          md_cnt_d   = C_MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == '0) begin
          md_state_d = MD_IDLE;
        end else begin
          md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        md_state_d = MD_IDLE;
        md_cnt_d   = '0;
      end
    endcase
    md_busy_d = (md_state_d == MD_BUSY);
  end

  // Saturating performance counters next state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset aborts any mul/div in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state_q  <= MD_IDLE;
      md_cnt_q    <= '0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      md_state_q  <= md_state_d;
      md_cnt_q    <= md_cnt_d;
      md_busy_q   <= md_busy_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign md_busy   = md_busy_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_unit
// Description : Directed bench for hazard_ctrl_unit: vector table for the
//               combinational stall/flush/forward rules, hand sequences for
//               multi-cycle pipeline scenarios, mul/div and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic       id_use_rs, id_use_rt, id_branch, id_br_taken, id_jump;
  logic       id_muldiv, id_hilo_rd;
  logic       ex_regwr, ex_memrd, mem_regwr, mem_memrd, wb_regwr;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy;
  logic [1:0] fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b;
  logic [15:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl_unit #(.REG_AW(5), .MULDIV_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_br_taken(id_br_taken), .id_jump(id_jump),
    .id_muldiv(id_muldiv), .id_hilo_rd(id_hilo_rd),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .ex_dst(ex_dst), .mem_regwr(mem_regwr), .mem_memrd(mem_memrd),
    .mem_dst(mem_dst), .wb_regwr(wb_regwr), .wb_dst(wb_dst),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b),
    .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b), .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // idf = {use_rs,use_rt,branch,taken,jump,muldiv,hilo}; exf/memf = {regwr,memrd}
  // ctl = {pc_write,if_id_write,if_id_flush,id_ex_flush}
  // fwd = {fwd_ex_a,fwd_ex_b,fwd_id_a,fwd_id_b}
  typedef struct {
    string      nm;
    logic [4:0] rs, rt;
    logic [6:0] idf;
    logic [4:0] exrs, exrt;
    logic [1:0] exf;
    logic [4:0] exdst;
    logic [1:0] memf;
    logic [4:0] memdst;
    logic       wbwr;
    logic [4:0] wbdst;
    logic [3:0] ctl;
    logic [7:0] fwd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [4:0] rs, logic [4:0] rt, logic [6:0] idf,
                              logic [4:0] exrs, logic [4:0] exrt, logic [1:0] exf,
                              logic [4:0] exdst, logic [1:0] memf, logic [4:0] memdst,
                              logic wbwr, logic [4:0] wbdst, logic [3:0] ctl, logic [7:0] fwd);
    vec_t v;
    v.nm = nm; v.rs = rs; v.rt = rt; v.idf = idf; v.exrs = exrs; v.exrt = exrt;
    v.exf = exf; v.exdst = exdst; v.memf = memf; v.memdst = memdst;
    v.wbwr = wbwr; v.wbdst = wbdst; v.ctl = ctl; v.fwd = fwd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_branch = 0;
    id_br_taken = 0; id_jump = 0; id_muldiv = 0; id_hilo_rd = 0;
    ex_rs = '0; ex_rt = '0; ex_regwr = 0; ex_memrd = 0; ex_dst = '0;
    mem_regwr = 0; mem_memrd = 0; mem_dst = '0; wb_regwr = 0; wb_dst = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input logic [3:0] exp);
    #1;
    chk({nm, "_ctl"}, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, {28'd0, exp});
  endtask

  task automatic chk_cnt(input string nm, input int st, input int fl);
    chk({nm, "_stall_cnt"}, {16'd0, stall_cnt}, st);
    chk({nm, "_flush_cnt"}, {16'd0, flush_cnt}, fl);
  endtask

  initial begin
    clr();
    reset = 1'b1;

    vecs.push_back(mk("idle",          0, 0, 7'b0000000, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 4'b1100, 8'h00));
    vecs.push_back(mk("ld_use_rs",     2, 0, 7'b1000000, 0, 0, 2'b11, 2, 2'b00, 0, 0, 0, 4'b0001, 8'h00));
    vecs.push_back(mk("ld_use_rt",     7, 2, 7'b0100000, 0, 0, 2'b11, 2, 2'b00, 0, 0, 0, 4'b0001, 8'h00));
    vecs.push_back(mk("ld_no_use",     7, 2, 7'b0000000, 0, 0, 2'b11, 2, 2'b00, 0, 0, 0, 4'b1100, 8'h00));
    vecs.push_back(mk("dst_zero",      0, 0, 7'b1100000, 0, 0, 2'b11, 0, 2'b10, 0, 1, 0, 4'b1100, 8'h00));
    vecs.push_back(mk("br_ex_alu",     5, 0, 7'b1010000, 0, 0, 2'b10, 5, 2'b00, 0, 0, 0, 4'b0001, 8'h00));
    vecs.push_back(mk("br_mem_taken",  5, 0, 7'b1011000, 0, 0, 2'b00, 0, 2'b10, 5, 0, 0, 4'b1110, 8'b00_00_01_00));
    vecs.push_back(mk("br_mem_load",   0, 5, 7'b0110000, 0, 0, 2'b00, 0, 2'b11, 5, 0, 0, 4'b0001, 8'h00));
    vecs.push_back(mk("br_not_taken",  1, 2, 7'b1110000, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 4'b1100, 8'h00));
    vecs.push_back(mk("jump",          0, 0, 7'b0000100, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 4'b1110, 8'h00));
    vecs.push_back(mk("jr_ex_alu",    31, 0, 7'b1000100, 0, 0, 2'b10,31, 2'b00, 0, 0, 0, 4'b0001, 8'h00));
    vecs.push_back(mk("jr_rt_ignored", 1, 4, 7'b1100100, 0, 0, 2'b10, 4, 2'b00, 0, 0, 0, 4'b1110, 8'h00));
    vecs.push_back(mk("ex_fwd_mem_wb", 0, 0, 7'b0000000, 3, 4, 2'b00, 0, 2'b10, 3, 1, 4, 4'b1100, 8'b01_10_00_00));
    vecs.push_back(mk("mem_beats_wb",  6, 6, 7'b1000000, 6, 6, 2'b00, 0, 2'b10, 6, 1, 6, 4'b1100, 8'b01_01_01_00));
    vecs.push_back(mk("mem_ld_no_id",  6, 0, 7'b1000000, 6, 0, 2'b00, 0, 2'b11, 6, 1, 6, 4'b1100, 8'b01_00_10_00));
    vecs.push_back(mk("mem_wr_off",    6, 0, 7'b1000000, 6, 0, 2'b00, 0, 2'b00, 6, 0, 0, 4'b1100, 8'h00));
    vecs.push_back(mk("stall_beats_br",2, 0, 7'b1011000, 0, 0, 2'b11, 2, 2'b00, 0, 0, 0, 4'b0001, 8'h00));
    vecs.push_back(mk("wb_fwd_id_rt",  0, 9, 7'b0100000, 0, 0, 2'b00, 0, 2'b00, 0, 1, 9, 4'b1100, 8'b00_00_00_10));

    // Reset state
    tick();
    chk_ctl("rst", 4'b1100);
    chk("rst_md_busy", {31'd0, md_busy}, 0);
    chk_cnt("rst", 0, 0);
    reset = 1'b0;

    // Combinational rule table, one vector per cycle, mul/div idle throughout
    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      {id_use_rs, id_use_rt, id_branch, id_br_taken, id_jump, id_muldiv, id_hilo_rd} = vecs[i].idf;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      ex_rs = vecs[i].exrs; ex_rt = vecs[i].exrt;
      {ex_regwr, ex_memrd} = vecs[i].exf; ex_dst = vecs[i].exdst;
      {mem_regwr, mem_memrd} = vecs[i].memf; mem_dst = vecs[i].memdst;
      wb_regwr = vecs[i].wbwr; wb_dst = vecs[i].wbdst;
      chk_ctl(vecs[i].nm, vecs[i].ctl);
      chk({vecs[i].nm, "_fwd"}, {24'd0, fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b}, {24'd0, vecs[i].fwd});
    end

    // Clear counters before the sequences
    tick(); clr(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk_cnt("rst2", 0, 0);

    // lw $2 in EX, add $3,$2,$4 in ID
    clr(); id_rs = 2; id_use_rs = 1; id_rt = 4; id_use_rt = 1;
    ex_regwr = 1; ex_memrd = 1; ex_dst = 2;
    chk_ctl("lu_c0", 4'b0001);
    tick(); clr(); id_rs = 2; id_use_rs = 1; id_rt = 4; id_use_rt = 1;
    mem_regwr = 1; mem_memrd = 1; mem_dst = 2;
    chk_ctl("lu_c1", 4'b1100);
    tick(); clr(); ex_rs = 2; ex_rt = 4; wb_regwr = 1; wb_dst = 2;
    chk_ctl("lu_c2", 4'b1100);
    chk("lu_fwd_ex_a", {30'd0, fwd_ex_a}, 2);
    chk_cnt("lu", 1, 0);

    // beq $5 in ID, add $5 in EX, then taken
    tick(); clr(); id_branch = 1; id_rs = 5; id_use_rs = 1; ex_regwr = 1; ex_dst = 5;
    chk_ctl("ba_c0", 4'b0001);
    tick(); clr(); id_branch = 1; id_br_taken = 1; id_rs = 5; id_use_rs = 1;
    mem_regwr = 1; mem_dst = 5;
    chk_ctl("ba_c1", 4'b1110);
    chk("ba_fwd_id_a", {30'd0, fwd_id_a}, 1);
    tick(); clr();
    chk_cnt("ba", 2, 1);

    // beq $5 in ID, lw $5 in EX: two bubbles
    id_branch = 1; id_rs = 5; id_use_rs = 1; ex_regwr = 1; ex_memrd = 1; ex_dst = 5;
    chk_ctl("bl_c0", 4'b0001);
    tick(); clr(); id_branch = 1; id_rs = 5; id_use_rs = 1;
    mem_regwr = 1; mem_memrd = 1; mem_dst = 5;
    chk_ctl("bl_c1", 4'b0001);
    chk("bl_c1_fwd_id_a", {30'd0, fwd_id_a}, 0);
    tick(); clr(); id_branch = 1; id_rs = 5; id_use_rs = 1; wb_regwr = 1; wb_dst = 5;
    chk_ctl("bl_c2", 4'b1100);
    chk("bl_fwd_id_a", {30'd0, fwd_id_a}, 2);
    chk_cnt("bl", 4, 1);

    // mult issued, mflo follows while the unit is busy
    tick(); clr(); id_muldiv = 1;
    chk_ctl("md_issue", 4'b1100);
    chk("md_issue_busy", {31'd0, md_busy}, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); clr(); id_hilo_rd = 1;
      chk_ctl($sformatf("md_wait%0d", k), 4'b0001);
      chk($sformatf("md_wait%0d_busy", k), {31'd0, md_busy}, 1);
    end
    tick(); clr(); id_hilo_rd = 1;
    chk_ctl("md_done", 4'b1100);
    chk("md_done_busy", {31'd0, md_busy}, 0);
    chk_cnt("md", 8, 1);

    // Reset while busy, jump in ID with no hazard
    tick(); clr(); id_muldiv = 1;
    tick(); clr(); id_jump = 1;
    #1;
    chk("rb_busy_pre", {31'd0, md_busy}, 1);
    #1 reset = 1'b1;
    #1;
    chk("rb_busy_now", {31'd0, md_busy}, 0);
    chk_cnt("rb_now", 0, 0);
    tick(); reset = 1'b0;
    chk_ctl("rb_release", 4'b1110);
    tick();
    chk_ctl("rb_after", 4'b1110);
    chk("rb_after_busy", {31'd0, md_busy}, 0);
    chk_cnt("rb_after", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
